jtag_uart_ctrl_sched: RTL

Avalon master that sequences all traffic into the vJTAGUart control slave: 1-bit address, read/write strobes, 32-bit data, no waitrequest.
- Shares the TX direction between two byte requesters (game-of-life frame dump, status console) with round-robin arbitration.
- Gates TX writes on a write-space credit count read from the control register.
- Periodically polls the data register for RX bytes and presents them on a holding-register stream.
- Sits between the application logic and the jtag_uart_1 instance in the lab2 system.

---
 rtl/jtag_uart_pkg.sv | 20 ++
 rtl/jtag_rr_arb2.sv | 25 ++
 rtl/jtag_uart_ctrl_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jtag_uart_pkg.sv
// Shared definitions for the vJTAGUart control-slave scheduler: register map,
// field positions and the scheduler state encoding.
package jtag_uart_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int WSPACE_LSB = 16;
  localparam int RVALID_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    RD_CTRL,
    CAP_CTRL,
    WRITE,
    RD_DATA,
    CAP_DATA
  } schedState_t;

endpackage

// File: rtl/jtag_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester preferred when
// both are requesting and flips to the other side after each granted advance.
module jtag_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    grant = (req == 2'b11) ? ptr : req[1];
    gnt   = 2'b00;
    if (req != 2'b00) gnt = grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      ptr <= 1'b0;
    else if (advance && req != 2'b00)  ptr <= ~grant;
  end

endmodule

// File: rtl/jtag_uart_ctrl_sched.sv
// Avalon master scheduling TX writes (credit gated, round-robin between two
// requesters) and periodic RX polls into the vJTAGUart control slave.
//
//   state    | meaning
//   IDLE     | choose next action: write, credit poll, rx poll or count down gap
//   RD_CTRL  | read strobe on the control register
//   CAP_CTRL | load write-space credits from readdata
//   WRITE    | write strobe with the granted byte, ready pulse to its owner
//   RD_DATA  | read strobe on the data register
//   CAP_DATA | capture rx byte if RVALID, reload poll gap
module jtag_uart_ctrl_sched
  import jtag_uart_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int CREDIT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx0_valid,
  input  logic [7:0]  tx0_data,
  output logic        tx0_ready,
  input  logic        tx1_valid,
  input  logic [7:0]  tx1_data,
  output logic        tx1_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [7:0] GAP_INIT = 8'(POLL_GAP);

  schedState_t         state;
  logic [7:0]          gap;
  logic [CREDIT_W-1:0] credits;
  logic                ctrlEmpty;
  logic                grant;
  logic [1:0]          gnt;
  logic                anyTx;
  logic                canWrite;
  logic [31:0]         wspace;
  logic [CREDIT_W-1:0] wspaceCredits;

  assign anyTx         = tx0_valid | tx1_valid;
  assign canWrite      = (state == IDLE) && anyTx && (credits != '0);
  assign wspace        = avm_readdata >> WSPACE_LSB;
  assign wspaceCredits = wspace[CREDIT_W-1:0];

  jtag_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({tx1_valid, tx0_valid}),
    .advance (canWrite),
    .grant   (grant),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gap           <= GAP_INIT;
      credits       <= '0;
      ctrlEmpty     <= 1'b0;
      tx0_ready     <= 1'b0;
      tx1_ready     <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      avm_address   <= ADDR_DATA;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0;
    end else begin
      tx0_ready     <= 1'b0;
      tx1_ready     <= 1'b0;
      avm_address   <= ADDR_DATA;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (canWrite) begin
            state         <= WRITE;
            avm_write     <= 1'b1;
            avm_writedata <= {24'h0, grant ? tx1_data : tx0_data};
            tx0_ready     <= gnt[0];
            tx1_ready     <= gnt[1];
            credits       <= credits - 1'b1;
          end else if (anyTx && (!ctrlEmpty || gap == 8'd0)) begin
            // an empty space report holds off the next credit poll until the gap expires
            state       <= RD_CTRL;
            avm_read    <= 1'b1;
            avm_address <= ADDR_CTRL;
          end else if (!rx_valid && gap == 8'd0) begin
            state    <= RD_DATA;
            avm_read <= 1'b1;
          end else if (gap != 8'd0) begin
            gap <= gap - 8'd1;
          end
        end
        RD_CTRL: state <= CAP_CTRL;
        CAP_CTRL: begin
          credits   <= wspaceCredits;
          ctrlEmpty <= (wspaceCredits == '0);
          if (wspaceCredits == '0) gap <= GAP_INIT;
          state     <= IDLE;
        end
        WRITE:   state <= IDLE;
        RD_DATA: state <= CAP_DATA;
        CAP_DATA: begin
          if (avm_readdata[RVALID_BIT]) begin
            rx_valid <= 1'b1;
            rx_data  <= avm_readdata[7:0];
          end
          gap   <= GAP_INIT;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
